// File: rtl/instr_fetch_seq.sv
// Purpose: instruction fetch sequencer; holds the PC, reads instruction memory and issues words to decode.
// Latency: run in IDLE -> instrValid three cycles later; at most one instruction every three cycles.
// Backpressure: ISSUE holds instr/opcode/pcOut stable until instrValid & instrReady; no new read meanwhile.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   run                 leave IDLE (sampled in IDLE only)
//   imemRdEn/imemAddr   synchronous read request; data returns on imemData one cycle later
//   instrValid/Ready    issue handshake towards the decoder; instr, opcode, pcOut qualified by instrValid
//   branchTaken/Target  redirect taken on the handshake cycle only
//   flush/flushTarget   redirect from any non-IDLE state, overrides branch
//   fetchCount          completed handshakes, wraps at 2^16
module instr_fetch_seq #(
  parameter int unsigned           ADDRLEN   = 32,
  parameter int unsigned           INSTRLEN  = 32,
  parameter int unsigned           OPCODELEN = 7,
  parameter logic [ADDRLEN-1:0]    RESETPC   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic                 imemRdEn,
  output logic [ADDRLEN-1:0]   imemAddr,
  input  logic [INSTRLEN-1:0]  imemData,
  output logic                 instrValid,
  input  logic                 instrReady,
  output logic [INSTRLEN-1:0]  instr,
  output logic [OPCODELEN-1:0] opcode,
  output logic [ADDRLEN-1:0]   pcOut,
  input  logic                 branchTaken,
  input  logic [ADDRLEN-1:0]   branchTarget,
  input  logic                 flush,
  input  logic [ADDRLEN-1:0]   flushTarget,
  output logic [15:0]          fetchCount
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_ISSUE   = 2'd3;

  logic [1:0]          state, state_nxt;
  logic [ADDRLEN-1:0]  pc, pc_nxt;
  logic [INSTRLEN-1:0] instr_q;
  logic [ADDRLEN-1:0]  pc_out_q;
  logic [15:0]         fetch_cnt;
  logic                handshake;
  logic                flush_act;
  logic                capture_en;

  // Targets are word addresses; the low two bits are dropped on load.
  function automatic logic [ADDRLEN-1:0] word_align(input logic [ADDRLEN-1:0] a);
    return {a[ADDRLEN-1:2], 2'b00};
  endfunction

  // Outputs decode straight from the state register, so an async reset
  // clears the strobes without waiting for a clock edge.
  assign imemRdEn   = (state == ST_FETCH);
  assign imemAddr   = pc;
  assign instrValid = (state == ST_ISSUE);
  assign instr      = instr_q;
  assign opcode     = instr_q[OPCODELEN-1:0];
  assign pcOut      = pc_out_q;
  assign fetchCount = fetch_cnt;

  assign handshake  = instrValid & instrReady;
  assign flush_act  = flush & (state != ST_IDLE);
  // A flush during CAPTURE drops the returning word; instr keeps its old value.
  assign capture_en = (state == ST_CAPTURE) & ~flush;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_IDLE:    if (run) state_nxt = ST_FETCH;
      ST_FETCH:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (handshake) begin
          state_nxt = ST_FETCH;
          pc_nxt    = branchTaken ? word_align(branchTarget) : pc + ADDRLEN'(4);
        end
      end
      default:    state_nxt = ST_IDLE;
    endcase
    // Flush wins over everything, including a branch on the handshake cycle.
    if (flush_act) begin
      state_nxt = ST_FETCH;
      pc_nxt    = word_align(flushTarget);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESETPC;
      instr_q   <= '0;
      pc_out_q  <= '0;
      fetch_cnt <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture_en) begin
        instr_q  <= imemData;
        pc_out_q <= pc;
      end
      // A handshake coincident with a flush still counts as delivered.
      if (handshake) fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;

  localparam logic [31:0] K = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        instrReady = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = '0;
  logic        flush = 1'b0;
  logic [31:0] flushTarget = '0;

  logic        imemRdEn, instrValid;
  logic [31:0] imemAddr, instr, pcOut;
  logic [31:0] imemData;
  logic [6:0]  opcode;
  logic [15:0] fetchCount;

  logic        w_imemRdEn, w_instrValid;
  logic [31:0] w_imemAddr, w_instr, w_pcOut;
  logic [31:0] w_imemData;
  logic [6:0]  w_opcode;
  logic [15:0] w_fetchCount;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_w;

  always #5 clk = ~clk;

  instr_fetch_seq dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imemRdEn(imemRdEn), .imemAddr(imemAddr), .imemData(imemData),
    .instrValid(instrValid), .instrReady(instrReady),
    .instr(instr), .opcode(opcode), .pcOut(pcOut),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .flush(flush), .flushTarget(flushTarget), .fetchCount(fetchCount)
  );

  instr_fetch_seq #(.RESETPC(32'hFFFFFFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imemRdEn(w_imemRdEn), .imemAddr(w_imemAddr), .imemData(w_imemData),
    .instrValid(w_instrValid), .instrReady(instrReady),
    .instr(w_instr), .opcode(w_opcode), .pcOut(w_pcOut),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .flush(flush), .flushTarget(flushTarget), .fetchCount(w_fetchCount)
  );

  // Instruction memories: word = address ^ K, returned one cycle after the strobe.
  always @(posedge clk) if (imemRdEn) imemData <= imemAddr ^ K;
  always @(posedge clk) if (w_imemRdEn) w_imemData <= w_imemAddr ^ K;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (instrValid !== 1'b0) $display("FAIL rst_valid got %b exp 0", instrValid); else n_pass++;
    n_total++; if (imemRdEn !== 1'b0) $display("FAIL rst_rden got %b exp 0", imemRdEn); else n_pass++;
    n_total++; if (imemAddr !== 32'h0) $display("FAIL rst_addr got %h exp 0", imemAddr); else n_pass++;
    n_total++; if (instr !== 32'h0) $display("FAIL rst_instr got %h exp 0", instr); else n_pass++;
    n_total++; if (pcOut !== 32'h0) $display("FAIL rst_pcout got %h exp 0", pcOut); else n_pass++;
    n_total++; if (fetchCount !== 16'h0) $display("FAIL rst_count got %h exp 0", fetchCount); else n_pass++;
    n_total++; if (w_imemAddr !== 32'hFFFFFFFC) $display("FAIL rst_w_addr got %h exp fffffffc", w_imemAddr); else n_pass++;
    rst_n = 1'b1;
    // flush in IDLE must be ignored
    flush = 1'b1; flushTarget = 32'h80;
    step();
    n_total++; if (imemRdEn !== 1'b0) $display("FAIL idle_flush_rden got %b exp 0", imemRdEn); else n_pass++;
    n_total++; if (imemAddr !== 32'h0) $display("FAIL idle_flush_addr got %h exp 0", imemAddr); else n_pass++;
    flush = 1'b0;
  endtask

  task automatic test_stream();
    run = 1'b1; instrReady = 1'b1;
    step();
    run = 1'b0;
    n_total++; if (imemRdEn !== 1'b1) $display("FAIL st_rden0 got %b exp 1", imemRdEn); else n_pass++;
    n_total++; if (imemAddr !== 32'h0) $display("FAIL st_addr0 got %h exp 0", imemAddr); else n_pass++;
    n_total++; if (instrValid !== 1'b0) $display("FAIL st_valid_c1 got %b exp 0", instrValid); else n_pass++;
    step();
    n_total++; if (instrValid !== 1'b0) $display("FAIL st_valid_c2 got %b exp 0", instrValid); else n_pass++;
    n_total++; if (imemRdEn !== 1'b0) $display("FAIL st_rden_c2 got %b exp 0", imemRdEn); else n_pass++;
    step();
    exp_w = 32'h0 ^ K;
    n_total++; if (instrValid !== 1'b1) $display("FAIL st_valid_c3 got %b exp 1", instrValid); else n_pass++;
    n_total++; if (instr !== exp_w) $display("FAIL st_instr0 got %h exp %h", instr, exp_w); else n_pass++;
    n_total++; if (opcode !== exp_w[6:0]) $display("FAIL st_opcode0 got %h exp %h", opcode, exp_w[6:0]); else n_pass++;
    n_total++; if (pcOut !== 32'h0) $display("FAIL st_pcout0 got %h exp 0", pcOut); else n_pass++;
    for (int k = 1; k <= 2; k++) begin
      step();
      n_total++; if (imemAddr !== 32'(4 * k) || imemRdEn !== 1'b1) $display("FAIL st_fetch%0d got addr %h rden %b exp %h 1", k, imemAddr, imemRdEn, 32'(4 * k)); else n_pass++;
      step();
      step();
      exp_w = 32'(4 * k) ^ K;
      n_total++; if (pcOut !== 32'(4 * k) || instrValid !== 1'b1) $display("FAIL st_issue%0d got pcout %h valid %b exp %h 1", k, pcOut, instrValid, 32'(4 * k)); else n_pass++;
      n_total++; if (instr !== exp_w) $display("FAIL st_instr%0d got %h exp %h", k, instr, exp_w); else n_pass++;
      n_total++; if (fetchCount !== 16'(k)) $display("FAIL st_count%0d got %0d exp %0d", k, fetchCount, k); else n_pass++;
    end
    step();
    n_total++; if (fetchCount !== 16'd3) $display("FAIL st_count3 got %0d exp 3", fetchCount); else n_pass++;
    n_total++; if (imemAddr !== 32'hC) $display("FAIL st_addr3 got %h exp c", imemAddr); else n_pass++;
    instrReady = 1'b0;
  endtask

  task automatic test_stall();
    step();
    step();
    n_total++; if (instrValid !== 1'b1 || pcOut !== 32'hC) $display("FAIL stall_enter got valid %b pcout %h exp 1 c", instrValid, pcOut); else n_pass++;
    // a branch without instrReady must be ignored
    branchTaken = 1'b1; branchTarget = 32'h200;
    exp_w = 32'hC ^ K;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++; if (instrValid !== 1'b1 || imemRdEn !== 1'b0) $display("FAIL stall%0d_strobes got valid %b rden %b exp 1 0", i, instrValid, imemRdEn); else n_pass++;
      n_total++; if (instr !== exp_w || opcode !== exp_w[6:0] || pcOut !== 32'hC) $display("FAIL stall%0d_hold got %h %h %h exp %h %h c", i, instr, opcode, pcOut, exp_w, exp_w[6:0]); else n_pass++;
    end
    instrReady = 1'b1; branchTaken = 1'b0;
    step();
    n_total++; if (imemRdEn !== 1'b1 || imemAddr !== 32'h10) $display("FAIL stall_release got rden %b addr %h exp 1 10", imemRdEn, imemAddr); else n_pass++;
    n_total++; if (fetchCount !== 16'd4) $display("FAIL stall_count got %0d exp 4", fetchCount); else n_pass++;
  endtask

  task automatic test_branch();
    step();
    step();
    n_total++; if (instrValid !== 1'b1 || pcOut !== 32'h10) $display("FAIL br_issue got valid %b pcout %h exp 1 10", instrValid, pcOut); else n_pass++;
    branchTaken = 1'b1; branchTarget = 32'h43;
    step();
    branchTaken = 1'b0;
    n_total++; if (imemRdEn !== 1'b1 || imemAddr !== 32'h40) $display("FAIL br_target got rden %b addr %h exp 1 40", imemRdEn, imemAddr); else n_pass++;
    n_total++; if (fetchCount !== 16'd5) $display("FAIL br_count got %0d exp 5", fetchCount); else n_pass++;
  endtask

  task automatic test_flush();
    step();  // CAPTURE of 0x40
    flush = 1'b1; flushTarget = 32'h100;
    step();
    flush = 1'b0;
    exp_w = 32'h10 ^ K;
    n_total++; if (imemRdEn !== 1'b1 || imemAddr !== 32'h100) $display("FAIL fl_target got rden %b addr %h exp 1 100", imemRdEn, imemAddr); else n_pass++;
    n_total++; if (instrValid !== 1'b0) $display("FAIL fl_valid got %b exp 0", instrValid); else n_pass++;
    n_total++; if (fetchCount !== 16'd5) $display("FAIL fl_count got %0d exp 5", fetchCount); else n_pass++;
    n_total++; if (instr !== exp_w || pcOut !== 32'h10) $display("FAIL fl_retain got %h %h exp %h 10", instr, pcOut, exp_w); else n_pass++;
    step();
    n_total++; if (instrValid !== 1'b0) $display("FAIL fl_valid_cap got %b exp 0", instrValid); else n_pass++;
    step();
    exp_w = 32'h100 ^ K;
    n_total++; if (instrValid !== 1'b1 || pcOut !== 32'h100 || instr !== exp_w) $display("FAIL fl_issue got %b %h %h exp 1 100 %h", instrValid, pcOut, instr, exp_w); else n_pass++;
    // flush on the handshake cycle: handshake counts, flushTarget beats branchTarget
    branchTaken = 1'b1; branchTarget = 32'h300; flush = 1'b1; flushTarget = 32'h205;
    step();
    branchTaken = 1'b0; flush = 1'b0;
    n_total++; if (imemAddr !== 32'h204 || instrValid !== 1'b0) $display("FAIL flhs_addr got %h valid %b exp 204 0", imemAddr, instrValid); else n_pass++;
    n_total++; if (fetchCount !== 16'd6) $display("FAIL flhs_count got %0d exp 6", fetchCount); else n_pass++;
  endtask

  task automatic test_reset_mid();
    step();
    step();
    n_total++; if (instrValid !== 1'b1) $display("FAIL rm_pre got %b exp 1", instrValid); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_total++; if (instrValid !== 1'b0) $display("FAIL rm_valid got %b exp 0", instrValid); else n_pass++;
    n_total++; if (imemAddr !== 32'h0 || w_imemAddr !== 32'hFFFFFFFC) $display("FAIL rm_pc got %h %h exp 0 fffffffc", imemAddr, w_imemAddr); else n_pass++;
    n_total++; if (fetchCount !== 16'h0 || instr !== 32'h0 || pcOut !== 32'h0) $display("FAIL rm_regs got %h %h %h exp 0 0 0", fetchCount, instr, pcOut); else n_pass++;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (imemRdEn !== 1'b0 || instrValid !== 1'b0) $display("FAIL rm_idle%0d got rden %b valid %b exp 0 0", i, imemRdEn, instrValid); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    run = 1'b1; instrReady = 1'b1;
    step();
    run = 1'b0;
    n_total++; if (w_imemRdEn !== 1'b1 || w_imemAddr !== 32'hFFFFFFFC) $display("FAIL wr_first got rden %b addr %h exp 1 fffffffc", w_imemRdEn, w_imemAddr); else n_pass++;
    step();
    step();
    exp_w = 32'hFFFFFFFC ^ K;
    n_total++; if (w_instrValid !== 1'b1 || w_pcOut !== 32'hFFFFFFFC || w_instr !== exp_w) $display("FAIL wr_issue got %b %h %h exp 1 fffffffc %h", w_instrValid, w_pcOut, w_instr, exp_w); else n_pass++;
    step();
    n_total++; if (w_imemRdEn !== 1'b1 || w_imemAddr !== 32'h0) $display("FAIL wr_next got rden %b addr %h exp 1 0", w_imemRdEn, w_imemAddr); else n_pass++;
    n_total++; if (w_fetchCount !== 16'd1 || imemAddr !== 32'h4) $display("FAIL wr_count got %0d addr %h exp 1 4", w_fetchCount, imemAddr); else n_pass++;
    instrReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Instruction fetch sequencer that produces opcodes for the control unit, driving the decode side of the same interface.
- Holds the PC and issues synchronous reads to instruction memory.
- Captures each returned word and presents it on a valid/ready handshake. The opcode field is split out for the decoder.
- Redirects the PC on a taken branch (at handshake) or on an asynchronous-to-flow flush request.

Parameters:
- ADDRLEN, 32, PC and instruction-memory address width.
- INSTRLEN, 32, instruction word width.
- OPCODELEN, 7, opcode field width, taken from instr[OPCODELEN-1:0].
- RESETPC, 0, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  allows leaving IDLE; sampled only in IDLE.
- imemRdEn  output  1  instruction memory read strobe.
- imemAddr  output  ADDRLEN  read address; equals pc.
- imemData  input  INSTRLEN  read data, valid exactly one cycle after imemRdEn.
- instrValid  output  1  instr/opcode/pcOut hold a valid instruction.
- instrReady  input  1  decoder accepts the instruction.
- instr  output  INSTRLEN  captured instruction word.
- opcode  output  OPCODELEN  instr[OPCODELEN-1:0].
- pcOut  output  ADDRLEN  address the current instr was fetched from.
- branchTaken  input  1  sampled only on the handshake cycle.
- branchTarget  input  ADDRLEN  next PC when branchTaken.
- flush  input  1  redirect request; accepted in any non-IDLE state.
- flushTarget  input  ADDRLEN  next PC when flush.
- fetchCount  output  16  number of completed handshakes, wraps at 2^16.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESETPC.
  - imemRdEn=0, instrValid=0, instr=0, pcOut=0, fetchCount=0.
  - Takes effect immediately, mid-operation included; any in-flight read data is discarded.
- States: IDLE, FETCH, CAPTURE, ISSUE.
- IDLE: all strobes low. run=1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - imemRdEn=1, imemAddr=pc, combinationally, for exactly one cycle.
  - -> CAPTURE.
- CAPTURE:
  - instr<=imemData, pcOut<=pc.
  - -> ISSUE.
- ISSUE:
  - instrValid=1; instr, opcode and pcOut are stable until the handshake.
  - Handshake = instrValid & instrReady in the same cycle.
  - On handshake: fetchCount+1; next pc = branchTaken ? branchTarget : pc+4; -> FETCH.
  - No handshake: stay; pc unchanged.
  - branchTaken without instrReady is ignored.
- Latency and throughput:
  - Run asserted in IDLE gives instrValid=1 three cycles later.
  - Max throughput is one instruction per 3 cycles; one read outstanding at most.
- PC arithmetic:
  - pc+4 wraps modulo 2^ADDRLEN; 0xFFFFFFFC -> 0x00000000.
  - Targets have bits[1:0] forced to 0 when loaded.
- Flush (highest priority, in FETCH, CAPTURE or ISSUE):
  - pc<=flushTarget (aligned), instrValid drops next cycle, -> FETCH.
  - A CAPTURE-cycle flush discards imemData.
  - A flush coincident with a handshake completes the handshake (fetchCount increments), but flushTarget overrides branchTarget.
  - flush in IDLE is ignored.
- instr retains its last value after a flush; only instrValid qualifies it.

Test Plan:
- Reset then run=1, instrReady=1, imem returns addr-indexed words -> imemAddr sequence 0x0, 0x4, 0x8; instrValid first seen 3 cycles after run; fetchCount=3 after 3 handshakes.
- instrReady held 0 for 5 cycles in ISSUE -> instr, opcode and pcOut unchanged; no imemRdEn pulse; the handshake on cycle 6 advances pc to pcOut+4.
- Handshake at pcOut=0x10 with branchTaken=1, branchTarget=0x43 -> next imemAddr=0x40.
- flush=1, flushTarget=0x100 during CAPTURE -> no instrValid for the discarded word; next imemAddr=0x100; fetchCount unchanged.
- RESETPC=0xFFFFFFFC -> fetch at 0xFFFFFFFC, then 0x00000000.
- rst_n pulsed low in ISSUE -> instrValid=0 and pc=RESETPC immediately (before the next clk edge); with run=0, state stays IDLE.
